// File: rtl/exe_stage_module_if.sv
// Bundle of ID/EX inputs, forwarding sources, branch outputs and EX/MEM
// register outputs of the execute stage.
//   slave  : the execute stage (consumes ID/EX fields, drives EX/MEM fields)
//   master : the surrounding pipeline / testbench
interface exe_stage_module_if #(
  parameter int WORD_LENGTH = 32,
  parameter int REG_ADDR_W  = 4
);
  logic                   freeze;
  logic                   forwarding_enable;
  logic [WORD_LENGTH-1:0] pc_in;
  logic [3:0]             execute_command_in;
  logic                   mem_read_en_in;
  logic                   mem_write_en_in;
  logic                   wb_enable_in;
  logic                   immediate_in;
  logic                   branch_taken_in;
  logic                   status_write_enable_in;
  logic [WORD_LENGTH-1:0] reg_file_in1;
  logic [WORD_LENGTH-1:0] reg_file_in2;
  logic [REG_ADDR_W-1:0]  dest_reg_in;
  logic [REG_ADDR_W-1:0]  src1_addr_in;
  logic [REG_ADDR_W-1:0]  src2_addr_in;
  logic [3:0]             status_reg_in;
  logic [23:0]            signed_immediate_in;
  logic [11:0]            shift_operand_in;
  logic                   mem_stage_wb_en;
  logic [REG_ADDR_W-1:0]  mem_stage_dest;
  logic [WORD_LENGTH-1:0] mem_stage_value;
  logic                   wb_stage_wb_en;
  logic [REG_ADDR_W-1:0]  wb_stage_dest;
  logic [WORD_LENGTH-1:0] wb_stage_value;
  logic                   branch_taken_out;
  logic [WORD_LENGTH-1:0] branch_address;
  logic [3:0]             status_register_out;
  logic [WORD_LENGTH-1:0] alu_result_out;
  logic [WORD_LENGTH-1:0] store_value_out;
  logic [REG_ADDR_W-1:0]  dest_reg_out;
  logic                   mem_read_en_out;
  logic                   mem_write_en_out;
  logic                   wb_enable_out;

  modport slave (
    input  freeze, forwarding_enable, pc_in, execute_command_in,
           mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in,
           branch_taken_in, status_write_enable_in, reg_file_in1, reg_file_in2,
           dest_reg_in, src1_addr_in, src2_addr_in, status_reg_in,
           signed_immediate_in, shift_operand_in,
           mem_stage_wb_en, mem_stage_dest, mem_stage_value,
           wb_stage_wb_en, wb_stage_dest, wb_stage_value,
    output branch_taken_out, branch_address, status_register_out,
           alu_result_out, store_value_out, dest_reg_out,
           mem_read_en_out, mem_write_en_out, wb_enable_out
  );

  modport master (
    output freeze, forwarding_enable, pc_in, execute_command_in,
           mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in,
           branch_taken_in, status_write_enable_in, reg_file_in1, reg_file_in2,
           dest_reg_in, src1_addr_in, src2_addr_in, status_reg_in,
           signed_immediate_in, shift_operand_in,
           mem_stage_wb_en, mem_stage_dest, mem_stage_value,
           wb_stage_wb_en, wb_stage_dest, wb_stage_value,
    input  branch_taken_out, branch_address, status_register_out,
           alu_result_out, store_value_out, dest_reg_out,
           mem_read_en_out, mem_write_en_out, wb_enable_out
  );
endinterface

// File: rtl/exe_stage_module.sv
// Execute stage plus EX/MEM pipeline register.
// Resolves operand forwarding (EX/MEM beats MEM/WB), builds operand 2
// (memory offset, rotated immediate or shifted Rm), runs the ALU, computes
// the branch target and owns the NZCV status register.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, overrides freeze
//   bus  - exe_stage_module_if.slave: ID/EX fields, forwarding sources,
//          combinational branch outputs and registered EX/MEM outputs
module exe_stage_module #(
  parameter int WORD_LENGTH = 32,
  parameter int REG_ADDR_W  = 4
) (
  input logic                clk,
  input logic                rst,
  exe_stage_module_if.slave  bus
);

  localparam int W = WORD_LENGTH;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input logic [4:0] amt);
    // A shift by W yields 0, so amt=0 returns v unchanged.
    rotr = (v >> amt) | (v << (6'd32 - {1'b0, amt}));
  endfunction

  function automatic logic [W-1:0] shift_rm(input logic [W-1:0] rm,
                                           input logic [1:0]   typ,
                                           input logic [4:0]   amt);
    logic signed [W-1:0] rm_s;
    rm_s = rm;
    case (typ)
      2'b00:   shift_rm = rm << amt;
      2'b01:   shift_rm = rm >> amt;
      2'b10:   shift_rm = W'(rm_s >>> amt);
      default: shift_rm = rotr(rm, amt);
    endcase
  endfunction

  function automatic logic [W-1:0] forward(input logic [REG_ADDR_W-1:0] addr,
                                          input logic [W-1:0]          rf_val,
                                          input logic                  fwd_en,
                                          input logic                  m_en,
                                          input logic [REG_ADDR_W-1:0] m_dst,
                                          input logic [W-1:0]          m_val,
                                          input logic                  w_en,
                                          input logic [REG_ADDR_W-1:0] w_dst,
                                          input logic [W-1:0]          w_val);
    if (fwd_en && m_en && (m_dst == addr))
      forward = m_val;
    else if (fwd_en && w_en && (w_dst == addr))
      forward = w_val;
    else
      forward = rf_val;
  endfunction

  logic [W-1:0] op1, src2_val, op2, alu_res;
  logic [W-1:0] add_b;
  logic         add_c, arith;
  logic [W:0]   sum;
  logic [3:0]   flags;
  logic         cin;

  // N and Z of the captured status are recomputed here, never consumed.
  logic unused_status;
  assign unused_status = &{1'b0, bus.status_reg_in[3:2]};

  assign cin = bus.status_reg_in[1];

  assign bus.branch_taken_out = bus.branch_taken_in;
  assign bus.branch_address   = bus.pc_in +
                                {{6{bus.signed_immediate_in[23]}}, bus.signed_immediate_in, 2'b00};

  always_comb begin
    op1 = forward(bus.src1_addr_in, bus.reg_file_in1, bus.forwarding_enable,
                  bus.mem_stage_wb_en, bus.mem_stage_dest, bus.mem_stage_value,
                  bus.wb_stage_wb_en, bus.wb_stage_dest, bus.wb_stage_value);
    src2_val = forward(bus.src2_addr_in, bus.reg_file_in2, bus.forwarding_enable,
                       bus.mem_stage_wb_en, bus.mem_stage_dest, bus.mem_stage_value,
                       bus.wb_stage_wb_en, bus.wb_stage_dest, bus.wb_stage_value);
  end

  always_comb begin
    if (bus.mem_read_en_in || bus.mem_write_en_in)
      op2 = {{(W-12){1'b0}}, bus.shift_operand_in};
    else if (bus.immediate_in)
      op2 = rotr({{(W-8){1'b0}}, bus.shift_operand_in[7:0]},
                 {bus.shift_operand_in[11:8], 1'b0});
    else
      op2 = shift_rm(src2_val, bus.shift_operand_in[6:5], bus.shift_operand_in[11:7]);
  end

  // Subtractions run through the same adder as op1 + ~op2 + carry,
  // which makes C the inverted borrow directly.
  always_comb begin
    add_b   = op2;
    add_c   = 1'b0;
    arith   = 1'b0;
    alu_res = '0;
    case (bus.execute_command_in)
      4'b0001: alu_res = op2;
      4'b1001: alu_res = ~op2;
      4'b0010: arith = 1'b1;
      4'b0011: begin arith = 1'b1; add_c = cin; end
      4'b0100: begin arith = 1'b1; add_b = ~op2; add_c = 1'b1; end
      4'b0101: begin arith = 1'b1; add_b = ~op2; add_c = cin; end
      4'b0110: alu_res = op1 & op2;
      4'b0111: alu_res = op1 | op2;
      4'b1000: alu_res = op1 ^ op2;
      default: alu_res = '0;
    endcase
    sum = {1'b0, op1} + {1'b0, add_b} + {{W{1'b0}}, add_c};
    if (arith)
      alu_res = sum[W-1:0];
    flags[3] = alu_res[W-1];
    flags[2] = (alu_res == '0);
    if (arith) begin
      flags[1] = sum[W];
      flags[0] = (op1[W-1] == add_b[W-1]) && (sum[W-1] != op1[W-1]);
    end else begin
      flags[1] = bus.status_reg_in[1];
      flags[0] = bus.status_reg_in[0];
    end
  end

  // ---- EX/MEM boundary ----
  logic [W-1:0]          alu_result_p1, store_value_p1;
  logic [REG_ADDR_W-1:0] dest_reg_p1;
  logic                  mem_read_p1, mem_write_p1, wb_en_p1;
  logic [3:0]            status_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_p1  <= '0;
      store_value_p1 <= '0;
      dest_reg_p1    <= '0;
      mem_read_p1    <= 1'b0;
      mem_write_p1   <= 1'b0;
      wb_en_p1       <= 1'b0;
    end else if (!bus.freeze) begin
      alu_result_p1  <= alu_res;
      store_value_p1 <= src2_val;
      dest_reg_p1    <= bus.dest_reg_in;
      mem_read_p1    <= bus.mem_read_en_in;
      mem_write_p1   <= bus.mem_write_en_in;
      wb_en_p1       <= bus.wb_enable_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      status_p1 <= 4'b0000;
    else if (!bus.freeze && bus.status_write_enable_in)
      status_p1 <= flags;
  end

  assign bus.alu_result_out      = alu_result_p1;
  assign bus.store_value_out     = store_value_p1;
  assign bus.dest_reg_out        = dest_reg_p1;
  assign bus.mem_read_en_out     = mem_read_p1;
  assign bus.mem_write_en_out    = mem_write_p1;
  assign bus.wb_enable_out       = wb_en_p1;
  assign bus.status_register_out = status_p1;

endmodule

// File: tb/tb_exe_stage_module.sv
module tb_exe_stage_module;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_stage_module_if bus ();
  exe_stage_module dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic        imm;
    logic        mw;
    logic        swe;
    logic        wb;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [11:0] shop;
    logic [3:0]  st_in;
    logic [31:0] exp_res;
    logic [3:0]  exp_st;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.freeze = 0; bus.forwarding_enable = 1; bus.pc_in = 0;
    bus.execute_command_in = 0; bus.mem_read_en_in = 0; bus.mem_write_en_in = 0;
    bus.wb_enable_in = 0; bus.immediate_in = 0; bus.branch_taken_in = 0;
    bus.status_write_enable_in = 0; bus.reg_file_in1 = 0; bus.reg_file_in2 = 0;
    bus.dest_reg_in = 4'h3; bus.src1_addr_in = 4'h1; bus.src2_addr_in = 4'h2;
    bus.status_reg_in = 0; bus.signed_immediate_in = 0; bus.shift_operand_in = 0;
    bus.mem_stage_wb_en = 0; bus.mem_stage_dest = 4'hF; bus.mem_stage_value = 0;
    bus.wb_stage_wb_en = 0; bus.wb_stage_dest = 4'hF; bus.wb_stage_value = 0;
  endtask

  task automatic apply(input vec_t v);
    bus.execute_command_in = v.op; bus.immediate_in = v.imm;
    bus.mem_write_en_in = v.mw; bus.status_write_enable_in = v.swe;
    bus.wb_enable_in = v.wb; bus.reg_file_in1 = v.in1; bus.reg_file_in2 = v.in2;
    bus.shift_operand_in = v.shop; bus.status_reg_in = v.st_in;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         op     imm   mw    swe   wb    in1           in2           shop     st_in    exp_res       exp_st
    vecs[0]  = '{4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5,        32'd7,        12'h000, 4'b0000, 32'd12,       4'b0000};
    vecs[1]  = '{4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3,        32'd3,        12'h000, 4'b0000, 32'd0,        4'b0110};
    vecs[2]  = '{4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 32'd1,        12'h000, 4'b0000, 32'h80000000, 4'b1001};
    vecs[3]  = '{4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0,        32'h11,       12'h4FF, 4'b0000, 32'hFF000000, 4'b1001};
    vecs[4]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,        32'h80000000, 12'h240, 4'b0000, 32'hF8000000, 4'b1001};
    vecs[5]  = '{4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 32'd1,        32'd2,        12'h000, 4'b0010, 32'd4,        4'b0000};
    vecs[6]  = '{4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 32'd5,        32'd3,        12'h000, 4'b0000, 32'd1,        4'b0010};
    vecs[7]  = '{4'h6, 1'b0, 1'b0, 1'b1, 1'b1, 32'hF0F0,     32'h0FF0,     12'h000, 4'b0011, 32'h00F0,     4'b0011};
    vecs[8]  = '{4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFF,       32'hFF,       12'h000, 4'b0000, 32'd0,        4'b0100};
    vecs[9]  = '{4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0F,       32'hF0,       12'h000, 4'b0000, 32'hFF,       4'b0100};
    vecs[10] = '{4'h9, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0,        32'd0,        12'h000, 4'b0000, 32'hFFFFFFFF, 4'b1000};
    vecs[11] = '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000,     32'hDEAD,     12'h004, 4'b0000, 32'h1004,     4'b1000};
    vecs[12] = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,        32'd1,        12'hF80, 4'b0000, 32'h80000000, 4'b1000};
    vecs[13] = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,        32'hAB,       12'h460, 4'b0000, 32'hAB000000, 4'b1000};
    vecs[14] = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,        32'h12345678, 12'h020, 4'b0000, 32'h12345678, 4'b1000};
    vecs[15] = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 32'd9,        32'd9,        12'h000, 4'b0000, 32'd0,        4'b1000};
    vecs[16] = '{4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 32'd1,        32'd2,        12'h000, 4'b0000, 32'hFFFFFFFF, 4'b1000};

    clear_inputs();
    bus.wb_enable_in = 1;
    bus.execute_command_in = 4'h1;
    bus.reg_file_in2 = 32'h55;
    rst = 1;
    tick();
    chk("reset_alu", bus.alu_result_out, 32'd0);
    chk("reset_status", {28'd0, bus.status_register_out}, 32'd0);
    chk("reset_wb", {31'd0, bus.wb_enable_out}, 32'd0);
    chk("reset_store", bus.store_value_out, 32'd0);
    rst = 0;
    clear_inputs();

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i]);
      tick();
      chk($sformatf("vec%0d_res", i), bus.alu_result_out, vecs[i].exp_res);
      chk($sformatf("vec%0d_status", i), {28'd0, bus.status_register_out}, {28'd0, vecs[i].exp_st});
      chk($sformatf("vec%0d_store", i), bus.store_value_out, vecs[i].in2);
      chk($sformatf("vec%0d_wb", i), {31'd0, bus.wb_enable_out}, {31'd0, vecs[i].wb});
      chk($sformatf("vec%0d_memw", i), {31'd0, bus.mem_write_en_out}, {31'd0, vecs[i].mw});
    end

    // Forwarding: MEM beats WB, WB alone, bypass when disabled
    clear_inputs();
    bus.execute_command_in = 4'h2; bus.src1_addr_in = 4'h4; bus.src2_addr_in = 4'h4;
    bus.reg_file_in1 = 32'h11; bus.reg_file_in2 = 32'h22; bus.immediate_in = 1;
    bus.shift_operand_in = 12'h000;
    bus.mem_stage_wb_en = 1; bus.mem_stage_dest = 4'h4; bus.mem_stage_value = 32'hAA;
    bus.wb_stage_wb_en = 1;  bus.wb_stage_dest = 4'h4;  bus.wb_stage_value = 32'hBB;
    tick();
    chk("fwd_mem_res", bus.alu_result_out, 32'hAA);
    chk("fwd_mem_store", bus.store_value_out, 32'hAA);
    bus.mem_stage_dest = 4'h9;
    tick();
    chk("fwd_wb_res", bus.alu_result_out, 32'hBB);
    chk("fwd_wb_store", bus.store_value_out, 32'hBB);
    bus.mem_stage_dest = 4'h4;
    bus.forwarding_enable = 0;
    tick();
    chk("fwd_off_res", bus.alu_result_out, 32'h11);
    chk("fwd_off_store", bus.store_value_out, 32'h22);

    // Branch target is combinational
    clear_inputs();
    bus.pc_in = 32'h100; bus.signed_immediate_in = 24'hFFFFFE; bus.branch_taken_in = 1;
    #1;
    chk("br_addr_neg", bus.branch_address, 32'hF8);
    chk("br_taken", {31'd0, bus.branch_taken_out}, 32'd1);
    bus.pc_in = 32'h200; bus.signed_immediate_in = 24'h000010; bus.branch_taken_in = 0;
    #1;
    chk("br_addr_pos", bus.branch_address, 32'h240);
    chk("br_not_taken", {31'd0, bus.branch_taken_out}, 32'd0);

    // Freeze holds both EX/MEM and status; reset overrides freeze
    clear_inputs();
    bus.execute_command_in = 4'h4; bus.reg_file_in1 = 32'd2; bus.reg_file_in2 = 32'd5;
    bus.status_write_enable_in = 1; bus.wb_enable_in = 1;
    tick();
    chk("pre_freeze_res", bus.alu_result_out, 32'hFFFFFFFD);
    chk("pre_freeze_status", {28'd0, bus.status_register_out}, 32'h8);
    bus.freeze = 1;
    for (int i = 0; i < 3; i++) begin
      bus.execute_command_in = 4'h2; bus.reg_file_in1 = 32'd100 + i; bus.reg_file_in2 = 0;
      bus.wb_enable_in = 0; bus.status_write_enable_in = 1; bus.mem_write_en_in = 1;
      tick();
      chk($sformatf("freeze%0d_res", i), bus.alu_result_out, 32'hFFFFFFFD);
      chk($sformatf("freeze%0d_status", i), {28'd0, bus.status_register_out}, 32'h8);
      chk($sformatf("freeze%0d_wb", i), {31'd0, bus.wb_enable_out}, 32'd1);
      chk($sformatf("freeze%0d_memw", i), {31'd0, bus.mem_write_en_out}, 32'd0);
    end
    rst = 1;
    tick();
    chk("rst_freeze_res", bus.alu_result_out, 32'd0);
    chk("rst_freeze_status", {28'd0, bus.status_register_out}, 32'd0);
    chk("rst_freeze_wb", {31'd0, bus.wb_enable_out}, 32'd0);
    chk("rst_freeze_store", bus.store_value_out, 32'd0);
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
